// File: rtl/button_increment_conditioner.sv
// Pushbutton front end: synchronizes the raw button, debounces press and release,
// and emits a one-cycle increment pulse per accepted press (plus optional auto-repeat).
module button_increment_conditioner #(
  parameter int DEBOUNCE_CYCLES      = 1000000,
  parameter int REPEAT_EN            = 0,
  parameter int REPEAT_DELAY_CYCLES  = 50000000,
  parameter int REPEAT_PERIOD_CYCLES = 20000000
) (
  input  logic BrdClk,
  input  logic aReset,
  input  logic aButton,
  output logic bIncrement,
  output logic bPressed,
  output logic bRepeatActive
);

  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int REP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  localparam logic [DEB_W-1:0] DEB_TARGET  = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  state_t            state;
  state_t            nextState;
  logic              syncA;
  logic              sBtn;
  logic [DEB_W-1:0]  debCnt;
  logic [DEB_W-1:0]  debCntNext;
  logic [REP_W-1:0]  repCnt;
  logic [REP_W-1:0]  repCntNext;
  logic [REP_W-1:0]  repLast;
  logic              incNext;
  logic              repActNext;

  // State, counters, synchronizer and registered outputs; reset wins over everything.
  always_ff @(posedge BrdClk) begin
    if (aReset) begin
      syncA         <= 1'b0;
      sBtn          <= 1'b0;
      state         <= IDLE;
      debCnt        <= '0;
      repCnt        <= '0;
      bIncrement    <= 1'b0;
      bRepeatActive <= 1'b0;
    end else begin
      syncA         <= aButton;
      sBtn          <= syncA;
      state         <= nextState;
      debCnt        <= debCntNext;
      repCnt        <= repCntNext;
      bIncrement    <= incNext;
      bRepeatActive <= repActNext;
    end
  end

  // debCnt counts stable cycles seen in a wait state; reaching DEBOUNCE_CYCLES accepts the edge.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:         if (sBtn) nextState = PRESS_WAIT;
      PRESS_WAIT:   if (!sBtn) nextState = IDLE;
                    else if (debCnt == DEB_TARGET) nextState = HELD;
      HELD:         if (!sBtn) nextState = RELEASE_WAIT;
      RELEASE_WAIT: if (sBtn) nextState = HELD;
                    else if (debCnt == DEB_TARGET) nextState = IDLE;
      default:      nextState = IDLE;
    endcase
  end

  // Counter updates and pulse generation; repCnt is left untouched outside HELD so a
  // bounced release resumes the repeat timing where it stopped.
  always_comb begin
    debCntNext = debCnt;
    repCntNext = repCnt;
    incNext    = 1'b0;
    repActNext = bRepeatActive;
    bPressed   = (state == HELD) || (state == RELEASE_WAIT);
    repLast    = bRepeatActive ? PERIOD_LAST : DELAY_LAST;
    case (state)
      IDLE: begin
        debCntNext = '0;
        repActNext = 1'b0;
      end
      PRESS_WAIT: begin
        if (sBtn) begin
          if (debCnt == DEB_TARGET) begin
            incNext    = 1'b1;
            repCntNext = '0;
          end else begin
            debCntNext = debCnt + 1'b1;
          end
        end
      end
      HELD: begin
        if (!sBtn) begin
          debCntNext = '0;
        end else if (REPEAT_EN != 0) begin
          if (repCnt == repLast) begin
            incNext    = 1'b1;
            repCntNext = '0;
            repActNext = 1'b1;
          end else begin
            repCntNext = repCnt + 1'b1;
          end
        end
      end
      RELEASE_WAIT: begin
        if (!sBtn) begin
          if (debCnt == DEB_TARGET) begin
            repActNext = 1'b0;
          end else begin
            debCntNext = debCnt + 1'b1;
          end
        end
      end
      default: begin
        debCntNext = '0;
        repCntNext = '0;
      end
    endcase
  end

endmodule
